sram_dma_copier: RTL
====================

// Module: sram_dma_copier
// PURPOSE
//  Bus initiator for the 14-bit-word-address data SRAM write port. Copies LEN words from instruction ROM to SRAM,
//  or fills LEN SRAM words with a constant. Sits beside the CPU and is arbitrated onto the shared SRAM port via req/gnt.
//  Used to preload data images and clear buffers before kernel launch.
// PARAMETERS
//  AW  14  word-address width of ROM and SRAM (16K words each)
//  DW  32  data word width
//  LW  15  length width (allows 0..16384 words)
// PORTS
//  clk        in   1   clock; all state updates on posedge
//  reset      in   1   asynchronous, active-high reset
//  start      in   1   request a transfer; sampled only in IDLE
//  mode       in   1   0 = copy ROM->SRAM, 1 = fill with pattern
//  src_addr   in   AW  first ROM word address (copy mode only)
//  dst_addr   in   AW  first SRAM word address
//  len        in   LW  number of words to write
//  pattern    in   DW  fill value (fill mode only)
//  busy       out  1   transfer in progress (PRIME or RUN)
//  done       out  1   one-cycle pulse at completion
//  rom_addr   out  AW  ROM read address (ROM read is combinational)
//  rom_data   in   DW  ROM read data
//  sram_req   out  1   request for the SRAM port
//  sram_gnt   in   1   port granted this cycle
//  sram_addr  out  AW  SRAM write address
//  sram_we    out  1   SRAM write enable (= RUN & sram_gnt)
//  sram_wd    out  DW  SRAM write data
// BEHAVIOUR
//  Reset: state IDLE; busy, done, sram_req, sram_we = 0; rom_addr, sram_addr, sram_wd, all counters = 0.
//  Reset mid-transfer aborts immediately: no done pulse, SRAM contents already written stay written.
//  IDLE: start & len!=0 -> latch src/dst/mode/pattern; rd_left = wr_left = len; -> PRIME.
//        start & len==0 -> DONE, no write issued, busy never asserted. Start outside IDLE is ignored.
//  PRIME (1 cycle): data_q <= mode ? pattern : rom_data[rom_addr=src_cur]; src_cur++, rd_left--; -> RUN.
//  RUN: sram_req=1; sram_addr=dst_cur; sram_wd=data_q; sram_we=sram_gnt.
//       gnt=1: dst_cur++, wr_left--; if rd_left!=0 reload data_q from src_cur, src_cur++, rd_left--.
//       gnt=0: all registers hold (no skipped or duplicated word).
//       gnt=1 & wr_left==1 -> DONE.
//  DONE (1 cycle): done=1, busy=0, sram_req=0 -> IDLE; start in the following cycle is accepted.
//  Latency with gnt held high: start edge -> PRIME -> len RUN cycles -> done pulse on cycle len+2 after start accepted.
//  Address arithmetic is modulo 2^AW: 0x3fff + 1 wraps to 0x0000 for both src and dst.
//  rom_addr = src_cur at all times; rom_data ignored in fill mode and outside PRIME/RUN.
// STRUCTURE
//  Package dma_pkg: AW/DW/LW constants, state_t enum {IDLE, PRIME, RUN, DONE}, mode_t enum {COPY, FILL}.
//  Sub-module dma_addr_ctr (AW-bit, async reset to 0, load + increment enable), instantiated for src and dst.
//  Remaining FSM, length counters and data_q pipeline register live in the top module.
// TESTING (ROM image: 0=1111ffff 1=aaaacccc 2=deadbeaf 3=002f0123; sram_gnt=1 unless stated)
//  1 copy src=0 dst=0x100 len=4 -> SRAM[0x100..0x103]=1111ffff,aaaacccc,deadbeaf,002f0123; busy 5 cycles, done pulse on 6th.
//  2 fill pattern=cafef00d dst=0x3ffe len=3 -> writes at 0x3ffe,0x3fff,0x0000 all cafef00d; rom_data ignored.
//  3 copy len=4, drop gnt for 2 cycles after 1st write -> sram_we=0 and addr/wd held; same final SRAM as test 1; done 2 cycles later.
//  4 len=0 -> no sram_we, busy stays 0, done pulse the cycle after start.
//  5 start pulsed again during RUN -> ignored, single done; reset asserted mid-RUN -> outputs 0 at once, no done, IDLE.
//  6 back-to-back: 2nd start (copy src=2 dst=0x200 len=2) in cycle after done -> accepted; SRAM[0x200..0x201]=deadbeaf,002f0123.

Source files
------------

// File: rtl/dma_pkg.sv
// Shared constants and enumerations for the SRAM DMA copier.
package dma_pkg;

    // Word-address width of ROM and SRAM (16K words each)
    localparam int AW = 14;
    // Data word width
    localparam int DW = 32;
    // Length width: one bit wider than AW so a full 16384-word transfer fits
    localparam int LW = 15;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        PRIME = 2'd1,
        RUN   = 2'd2,
        DONE  = 2'd3
    } state_t;

    typedef enum logic {
        COPY = 1'b0,
        FILL = 1'b1
    } mode_t;

endpackage

// File: rtl/dma_addr_ctr.sv
// Loadable word-address counter; wraps modulo 2^W on increment.
module dma_addr_ctr #(
    parameter int W = 14
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         load,
    input  logic [W-1:0] load_val,
    input  logic         inc,
    output logic [W-1:0] cnt
);

    // Load has priority over increment; both are no-ops when idle.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cnt <= '0;
        end else if (load) begin
            cnt <= load_val;
        end else if (inc) begin
            cnt <= cnt + W'(1);
        end
    end

endmodule

// File: rtl/sram_dma_copier.sv
// SRAM write-port bus initiator: copies ROM words into SRAM or fills SRAM
// with a constant, arbitrated onto the shared port through req/gnt.
//
//  state | meaning
//  ------+-----------------------------------------------------------------
//  IDLE  | waiting for start; len==0 goes straight to DONE
//  PRIME | first data word fetched into data_q (ROM read or fill pattern)
//  RUN   | requesting the port; each granted cycle writes data_q and
//        | fetches the next word, a denied cycle holds everything
//  DONE  | one-cycle done pulse, then back to IDLE
module sram_dma_copier
    import dma_pkg::*;
(
    input  logic          clk,
    input  logic          reset,
    input  logic          start,
    input  logic          mode,
    input  logic [AW-1:0] src_addr,
    input  logic [AW-1:0] dst_addr,
    input  logic [LW-1:0] len,
    input  logic [DW-1:0] pattern,
    output logic          busy,
    output logic          done,
    output logic [AW-1:0] rom_addr,
    input  logic [DW-1:0] rom_data,
    output logic          sram_req,
    input  logic          sram_gnt,
    output logic [AW-1:0] sram_addr,
    output logic          sram_we,
    output logic [DW-1:0] sram_wd
);

    state_t        state;
    mode_t         mode_q;
    logic [DW-1:0] pattern_q;
    logic [DW-1:0] data_q;
    logic [LW-1:0] rd_left;
    logic [LW-1:0] wr_left;
    logic          busy_q;
    logic          done_q;
    logic          req_q;

    logic [AW-1:0] src_cur;
    logic [AW-1:0] dst_cur;

    logic          accept;
    logic          reload;
    logic          src_inc;
    logic          dst_inc;
    logic [DW-1:0] fetch;

    // Transfer-step decode shared by the FSM and both address counters.
    always_comb begin
        accept  = (state == IDLE) && start && (len != '0);
        reload  = (state == RUN) && sram_gnt && (rd_left != '0);
        src_inc = (state == PRIME) || reload;
        dst_inc = (state == RUN) && sram_gnt;
        fetch   = (mode_q == FILL) ? pattern_q : rom_data;
    end

    dma_addr_ctr #(.W(AW)) u_src_ctr (
        .clk      (clk),
        .reset    (reset),
        .load     (accept),
        .load_val (src_addr),
        .inc      (src_inc),
        .cnt      (src_cur)
    );

    dma_addr_ctr #(.W(AW)) u_dst_ctr (
        .clk      (clk),
        .reset    (reset),
        .load     (accept),
        .load_val (dst_addr),
        .inc      (dst_inc),
        .cnt      (dst_cur)
    );

    // Sequencer, length counters, fetch register and registered status outputs.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state     <= IDLE;
            mode_q    <= COPY;
            pattern_q <= '0;
            data_q    <= '0;
            rd_left   <= '0;
            wr_left   <= '0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            req_q     <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    done_q <= 1'b0;
                    if (start) begin
                        if (len != '0) begin
                            mode_q    <= mode_t'(mode);
                            pattern_q <= pattern;
                            rd_left   <= len;
                            wr_left   <= len;
                            busy_q    <= 1'b1;
                            state     <= PRIME;
                        end else begin
                            // Zero-length request completes without touching the port.
                            done_q <= 1'b1;
                            state  <= DONE;
                        end
                    end
                end
                PRIME: begin
                    data_q  <= fetch;
                    rd_left <= rd_left - LW'(1);
                    req_q   <= 1'b1;
                    state   <= RUN;
                end
                RUN: begin
                    if (sram_gnt) begin
                        wr_left <= wr_left - LW'(1);
                        if (rd_left != '0) begin
                            data_q  <= fetch;
                            rd_left <= rd_left - LW'(1);
                        end
                        if (wr_left == LW'(1)) begin
                            busy_q <= 1'b0;
                            req_q  <= 1'b0;
                            done_q <= 1'b1;
                            state  <= DONE;
                        end
                    end
                end
                DONE: begin
                    done_q <= 1'b0;
                    state  <= IDLE;
                end
                default: begin
                    busy_q <= 1'b0;
                    req_q  <= 1'b0;
                    done_q <= 1'b0;
                    state  <= IDLE;
                end
            endcase
        end
    end

    // Write strobe follows the grant in the same cycle; req is only high in RUN.
    assign sram_we   = req_q & sram_gnt;
    assign sram_addr = dst_cur;
    assign sram_wd   = data_q;
    assign rom_addr  = src_cur;
    assign busy      = busy_q;
    assign done      = done_q;
    assign sram_req  = req_q;

endmodule
